chan_sel_rr: RTL
================

# chan_sel_rr

Parametrised N-channel, W-bit registered channel selector. It is the successor to the combinational 4-way 5-bit selector. Each input channel has a valid/ready handshake. The block picks one channel per cycle, either by an external select or by round-robin arbitration, and holds the winning word in a single output register with its own valid/ready handshake. It sits between multiple data producers and one consumer, where source tracking and back-pressure are required.

## Interface
- `WIDTH`, default 5: data width per channel, 1..32.
- `CHANNELS`, default 4: number of input channels, 2..16.
- `SEL_W`, localparam: `$clog2(CHANNELS)`. Not overridable.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_ready`  out  CHANNELS  per-channel ready, combinational, at most one bit high.
- `sel`  in  SEL_W  channel select for fixed mode.
- `mode`  in  1  0 = fixed (use `sel`), 1 = round-robin.
- `out_data`  out  WIDTH  registered selected word.
- `out_chan`  out  SEL_W  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Grant computation (combinational):
  - Fixed mode: grant channel `sel` when `sel < CHANNELS` and `in_valid[sel]` is high. Otherwise no grant.
  - Round-robin mode: grant the first channel with `in_valid` high, searching `ptr+1, ptr+2, … ptr` modulo CHANNELS.
- `in_ready[g]` = `load && grant_valid && (g == grant)`. All other bits are 0.
- A transfer on channel g occurs when `in_valid[g] && in_ready[g]`.
- On a transfer:
  - `out_data` ← channel g data, `out_chan` ← g, `out_valid` ← 1.
  - In round-robin mode only, `ptr` ← g.
- When `load` is high with no grant, `out_valid` ← 0, and `out_data`/`out_chan` hold their previous values.
- When `load` is low, all output registers hold.
- `ptr` is not updated in fixed mode. It is retained across mode changes.
- A `mode` or `sel` change takes effect on the grant in the same cycle. No transfer in flight is lost.
- Wrap-around: when `ptr` = CHANNELS-1, the search starts at channel 0.

## Timing
- Reset values (async, on `rst_n` low):
  - `out_valid` = 0, `out_data` = 0, `out_chan` = 0.
  - `ptr` = CHANNELS-1, so the first round-robin grant favours channel 0.
  - `in_ready` is 0 for as long as no grant exists.
- Reset asserted mid-operation discards the word held in the output register. No partial state survives.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 word per cycle while `out_ready` stays high.
- Simultaneous `out_ready` and a new grant in the same cycle: the old word is consumed and the new word is loaded on the same edge. There is no bubble.
- Back-pressure: `out_valid && !out_ready` forces all `in_ready` to 0. `out_data` stays stable until accepted.

## Configuration
- `CHAN_SEL_RR_EN`:
  - Defined: round-robin mode and `ptr` are compiled in. `mode` behaves as specified above.
  - Undefined: `ptr` logic is removed, `mode` is ignored, and the block always uses fixed-`sel` selection. The port list is unchanged.

## Test plan
- Fixed select, WIDTH=5, CHANNELS=4. Data 8/6/4/2 on channels 0..3, all valid, `mode`=0, `sel`=3, `out_ready`=1. Required: next cycle `out_data`=2, `out_chan`=3; `in_ready`=4'b1000 every cycle.
- Round-robin fairness. All four channels valid continuously, `mode`=1, `out_ready`=1. Required: `out_chan` sequence 0,1,2,3,0,1; `out_data` sequence 8,6,4,2,8,6.
- Sparse round-robin. Only channels 1 and 3 valid. Required: `out_chan` alternates 1,3,1,3; channels 0 and 2 never see `in_ready`.
- Back-pressure. `out_ready`=0 for 3 cycles after the first load. Required: `out_data` and `out_chan` hold; `in_ready`=0 throughout; the pending word is delivered on the cycle `out_ready` rises, and the next word follows with no bubble.
- No valid input or out-of-range `sel`. With CHANNELS=3, `sel`=3, `mode`=0. Required: `in_ready`=0 and `out_valid` drops to 0 after the current word is consumed.
- Reset mid-stream. Assert `rst_n`=0 while `out_valid`=1. Required: asynchronously `out_valid`=0, `out_data`=0, `out_chan`=0; the first round-robin grant after release is channel 0.

Source files
------------

// File: rtl/chan_sel_rr.sv
// chan_sel_rr: N-channel registered selector with per-channel valid/ready and one output register.
// Round-robin arbitration is compiled in only when CHAN_SEL_RR_EN is defined; otherwise fixed `sel` selection.
module chan_sel_rr #(
  parameter  int WIDTH    = 5,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    w_chan_data [CHANNELS];
  logic [CHANNELS-1:0] w_sel_hit;
  logic [CHANNELS-1:0] w_grant_oh;
  logic                w_load;
  logic                w_fix_valid;
  logic                w_grant_valid;
  logic [SEL_W-1:0]    w_grant;
  logic [WIDTH-1:0]    w_mux_data;

  logic [WIDTH-1:0]    r_out_data;
  logic [SEL_W-1:0]    r_out_chan;
  logic                r_out_valid;

  genvar gi;

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign w_sel_hit[gi]   = (sel == SEL_W'(gi));
      assign w_grant_oh[gi]  = w_grant_valid && (w_grant == SEL_W'(gi));
    end
  endgenerate

  // An out-of-range sel matches no channel, so it never produces a grant.
  assign w_fix_valid = |(w_sel_hit & in_valid);
  assign w_load      = !r_out_valid || out_ready;

`ifdef CHAN_SEL_RR_EN
  logic [SEL_W-1:0]      r_ptr;
  logic [SEL_W:0]        w_shamt;
  logic [2*CHANNELS-1:0] w_dbl;
  logic [CHANNELS-1:0]   w_rot;
  logic [CHANNELS-1:0]   w_seen;
  logic [SEL_W-1:0]      w_off_acc [CHANNELS];
  logic [SEL_W:0]        w_rr_sum;
  logic [SEL_W-1:0]      w_rr_grant;
  logic                  w_rr_valid;

  // w_rot[k] is the valid bit of channel (ptr+1+k) mod CHANNELS.
  assign w_shamt = {1'b0, r_ptr} + (SEL_W+1)'(1);
  assign w_dbl   = {in_valid, in_valid};
  assign w_rot   = CHANNELS'(w_dbl >> w_shamt);

  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_rr
      if (gi == 0) begin : g_first
        assign w_seen[gi]    = w_rot[gi];
        assign w_off_acc[gi] = '0;
      end else begin : g_rest
        assign w_seen[gi]    = w_seen[gi-1] | w_rot[gi];
        assign w_off_acc[gi] = (w_rot[gi] && !w_seen[gi-1]) ? SEL_W'(gi) : w_off_acc[gi-1];
      end
    end
  endgenerate

  assign w_rr_valid = w_seen[CHANNELS-1];
  assign w_rr_sum   = {1'b0, r_ptr} + (SEL_W+1)'(1) + {1'b0, w_off_acc[CHANNELS-1]};
  assign w_rr_grant = (w_rr_sum >= (SEL_W+1)'(CHANNELS)) ?
                      SEL_W'(w_rr_sum - (SEL_W+1)'(CHANNELS)) : SEL_W'(w_rr_sum);

  assign w_grant_valid = mode ? w_rr_valid : w_fix_valid;
  assign w_grant       = mode ? w_rr_grant : sel;

  // The pointer only advances on a round-robin transfer; fixed mode leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SEL_W'(CHANNELS-1);
    end else if (w_load && w_grant_valid && mode) begin
      r_ptr <= w_grant;
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_grant_valid = w_fix_valid;
  assign w_grant       = sel;
`endif

  assign w_mux_data = w_chan_data[w_grant];
  assign in_ready   = w_grant_oh & {CHANNELS{w_load}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      if (w_grant_valid) begin
        r_out_data  <= w_mux_data;
        r_out_chan  <= w_grant;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
